// File: rtl/ifm_drain_reader.sv
// Purpose : drains one ping-pong IFM bank per frame (all maps, all words, in order) into a valid/ready stream.
// Latency : first m_valid two cycles after the start pulse is sampled; one word per cycle with m_ready held high.
// Backpressure: reads are issued only when the 2-entry output FIFO can absorb them; output holds while m_ready=0.
//
// Ports:
//   clk, reset (async, active-low)       - clocking / reset
//   start_from_previous / end_to_previous - frame handshake with the producing layer (pulses)
//   ready, overrun                        - idle indication / sticky lost-start flag
//   ifm_enable_read, ifm_address_read,
//   ifm_sel_map, ifm_sel_bank,
//   data_in_from_ifm                      - IFM memory read port (1-cycle read latency)
//   m_valid, m_ready, m_data, m_last      - output stream
module ifm_drain_reader #(
    parameter int DATA_WIDTH    = 32,
    parameter int IFM_SIZE      = 9,
    parameter int NUMBER_OF_IFM = 28,
    localparam int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
    localparam int MAP_SEL_BITS     = $clog2(NUMBER_OF_IFM)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_from_previous,
    output logic                        end_to_previous,
    output logic                        ready,
    output logic                        ifm_enable_read,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read,
    output logic [MAP_SEL_BITS-1:0]     ifm_sel_map,
    output logic                        ifm_sel_bank,
    input  logic [DATA_WIDTH-1:0]       data_in_from_ifm,
    output logic                        m_valid,
    output logic                        m_last,
    output logic [DATA_WIDTH-1:0]       m_data,
    input  logic                        m_ready,
    output logic                        overrun
);

    localparam logic [ADDRESS_SIZE_IFM-1:0] ADDR_LAST = ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE - 1);
    localparam logic [ADDRESS_SIZE_IFM-1:0] ADDR_ONE  = ADDRESS_SIZE_IFM'(1);
    localparam logic [MAP_SEL_BITS-1:0]     MAP_LAST  = MAP_SEL_BITS'(NUMBER_OF_IFM - 1);
    localparam logic [MAP_SEL_BITS-1:0]     MAP_ONE   = MAP_SEL_BITS'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t                        state;
    logic                          pending;
    logic [ADDRESS_SIZE_IFM-1:0]   addr_cnt;
    logic [MAP_SEL_BITS-1:0]       map_cnt;
    logic                          rd_inflight;
    logic                          rd_inflight_last;

    logic [DATA_WIDTH-1:0]         fifo_dat [2];
    logic [1:0]                    fifo_last;
    logic                          wr_ptr;
    logic                          rd_ptr;
    logic [1:0]                    fifo_cnt;

    logic                          pop;
    logic                          rd_last;
    logic [2:0]                    committed;

    assign m_valid          = (fifo_cnt != 2'd0);
    assign m_data           = fifo_dat[rd_ptr];
    assign m_last           = m_valid & fifo_last[rd_ptr];
    assign pop              = m_valid & m_ready;
    assign ready            = (state == IDLE) && !pending;
    assign ifm_address_read = addr_cnt;
    assign ifm_sel_map      = map_cnt;
    assign rd_last          = (addr_cnt == ADDR_LAST) && (map_cnt == MAP_LAST);

    // Words the FIFO is committed to hold after this cycle's pop: stored + in flight - leaving now.
    // Counting the pop keeps the pipe at one word per cycle while never exceeding two entries.
    assign committed       = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    assign ifm_enable_read = (state == DRAIN) && (committed < 3'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            pending          <= 1'b0;
            overrun          <= 1'b0;
            addr_cnt         <= '0;
            map_cnt          <= '0;
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
            fifo_dat[0]      <= '0;
            fifo_dat[1]      <= '0;
            fifo_last        <= 2'b00;
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            fifo_cnt         <= 2'd0;
            end_to_previous  <= 1'b0;
            ifm_sel_bank     <= 1'b0;
        end else begin
            end_to_previous  <= 1'b0;
            rd_inflight      <= ifm_enable_read;
            rd_inflight_last <= ifm_enable_read & rd_last;

            // Read data returns exactly one cycle after the strobe; capacity was reserved at issue.
            if (rd_inflight) begin
                fifo_dat[wr_ptr]  <= data_in_from_ifm;
                fifo_last[wr_ptr] <= rd_inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (start_from_previous || pending) begin
                        state    <= DRAIN;
                        addr_cnt <= '0;
                        map_cnt  <= '0;
                        // Consuming a stored start while a fresh one arrives keeps the fresh one.
                        pending  <= start_from_previous && pending;
                    end
                end
                DRAIN: begin
                    if (ifm_enable_read) begin
                        if (rd_last) begin
                            // Counters stay on the final address so the read port holds its value.
                            state <= FLUSH;
                        end else if (addr_cnt == ADDR_LAST) begin
                            addr_cnt <= '0;
                            map_cnt  <= map_cnt + MAP_ONE;
                        end else begin
                            addr_cnt <= addr_cnt + ADDR_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (pop && m_last) begin
                        state           <= IDLE;
                        end_to_previous <= 1'b1;
                        ifm_sel_bank    <= ~ifm_sel_bank;
                    end
                end
                default: state <= IDLE;
            endcase

            // Outside IDLE a start is remembered once; a second one is lost and flagged.
            if (state != IDLE && start_from_previous) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifm_drain_reader.sv
// Bench for ifm_drain_reader with 2x2 maps, 2 maps per frame (8 words per frame).
// Memory returns bank*0x100 + map*0x10 + addr one cycle after each read strobe.
module tb_ifm_drain_reader;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          end_pulse;
    logic          ready;
    logic          ren;
    logic [1:0]    raddr;
    logic [0:0]    rmap;
    logic          rbank;
    logic [DW-1:0] mem_dat;
    logic          m_valid;
    logic          m_last;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          overrun;

    int vectors;
    int miscompares;
    int cyc;

    logic [DW:0] acc_q[$];
    int          acc_cyc[$];
    int          ep_count;
    int          ep_cyc[$];
    int          stall_bad;
    logic        prev_stall;
    logic [DW:0] prev_word;

    ifm_drain_reader #(
        .DATA_WIDTH   (DW),
        .IFM_SIZE     (2),
        .NUMBER_OF_IFM(2)
    ) dut (
        .clk                (clk),
        .reset              (rst_n),
        .start_from_previous(start),
        .end_to_previous    (end_pulse),
        .ready              (ready),
        .ifm_enable_read    (ren),
        .ifm_address_read   (raddr),
        .ifm_sel_map        (rmap),
        .ifm_sel_bank       (rbank),
        .data_in_from_ifm   (mem_dat),
        .m_valid            (m_valid),
        .m_last             (m_last),
        .m_data             (m_data),
        .m_ready            (m_ready),
        .overrun            (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 1-cycle read latency; garbage when not reading.
    always @(posedge clk) begin
        if (ren) mem_dat <= (32'(rbank) << 8) | (32'(rmap) << 4) | 32'(raddr);
        else     mem_dat <= 32'hDEAD_BEEF;
    end

    // Stream monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && (m_valid !== 1'b1 || {m_last, m_data} !== prev_word))
                stall_bad = stall_bad + 1;
            if (m_valid && m_ready) begin
                acc_q.push_back({m_last, m_data});
                acc_cyc.push_back(cyc);
            end
            if (end_pulse) begin
                ep_count = ep_count + 1;
                ep_cyc.push_back(cyc);
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [DW:0] exp_word(input int bank, input int i);
        exp_word = {(i == 7) ? 1'b1 : 1'b0, 32'(bank * 256 + (i / 4) * 16 + (i % 4))};
    endfunction

    task automatic clear_log();
        acc_q.delete();
        acc_cyc.delete();
        ep_cyc.delete();
        ep_count  = 0;
        stall_bad = 0;
    endtask

    // Pulse start for one cycle; s = cycle index of the edge that samples it.
    task automatic pulse_start(output int s);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 s = cyc; start = 1'b0;
    endtask

    task automatic wait_ends(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ep_count >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({ready, m_valid, m_last, ren, end_pulse, rbank, overrun} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b exp=1000000", {ready, m_valid, m_last, ren, end_pulse, rbank, overrun});
        end
        vectors++;
        if ({raddr, rmap, m_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_data addr=%0d map=%0d data=%h exp all 0", raddr, rmap, m_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int s; bit ok;
        m_ready = 1'b1;
        clear_log();
        pulse_start(s);
        wait_ends(1, 60, ok);
        vectors++;
        if (!ok || acc_q.size() != 8) begin
            miscompares++;
            $display("FAIL basic_done ended=%0d words=%0d exp 1/8", ok, acc_q.size());
        end
        for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
            vectors++;
            if (acc_q[i] !== exp_word(0, i) || acc_cyc[i] != s + 2 + i) begin
                miscompares++;
                $display("FAIL basic_word%0d got=%h@%0d exp=%h@%0d", i, acc_q[i], acc_cyc[i], exp_word(0, i), s + 2 + i);
            end
        end
        vectors++;
        if (ep_cyc.size() < 1 || ep_cyc[0] != s + 10 || rbank !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_end ep_cycles=%0d bank=%b exp ep@%0d bank=1", ep_cyc.size(), rbank, s + 10);
        end
        @(negedge clk);
        vectors++;
        if ({end_pulse, ren, ready, raddr, rmap} !== {1'b0, 1'b0, 1'b1, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL basic_idle end=%b ren=%b ready=%b addr=%0d map=%0d exp 0 0 1 3 1", end_pulse, ren, ready, raddr, rmap);
        end
    endtask

    task automatic test_reset_midframe();
        int s; int ep_before; bit hit;
        m_ready = 1'b1;
        clear_log();
        pulse_start(s);
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (acc_q.size() == 5) begin hit = 1'b1; break; end
        end
        rst_n = 1'b0;
        ep_before = ep_count;
        repeat (2) @(negedge clk);
        vectors++;
        if (!hit || {ready, m_valid, m_last, ren, end_pulse, rbank, overrun} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL midreset_ctrl reached5=%0d got=%b exp=1000000", hit, {ready, m_valid, m_last, ren, end_pulse, rbank, overrun});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (ep_count != ep_before) begin
            miscompares++;
            $display("FAIL midreset_noend got=%0d end pulses exp=0", ep_count - ep_before);
        end
        clear_log();
        pulse_start(s);
        wait_ends(1, 60, hit);
        vectors++;
        if (!hit || acc_q.size() != 8 || rbank !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_frame ended=%0d words=%0d bank=%b exp 1/8/1", hit, acc_q.size(), rbank);
        end
        for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
            vectors++;
            if (acc_q[i] !== exp_word(0, i)) begin
                miscompares++;
                $display("FAIL midreset_word%0d got=%h exp=%h", i, acc_q[i], exp_word(0, i));
            end
        end
    endtask

    task automatic test_backpressure();
        int s; bit ok;
        logic [3:0] pat;
        pat = 4'b1001;
        m_ready = 1'b1;
        clear_log();
        pulse_start(s);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1 m_ready = pat[k % 4];
            if (ep_count >= 1) begin ok = 1'b1; break; end
        end
        m_ready = 1'b1;
        vectors++;
        if (!ok || acc_q.size() != 8 || stall_bad != 0 || rbank !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_frame ended=%0d words=%0d stall_errs=%0d bank=%b exp 1/8/0/0", ok, acc_q.size(), stall_bad, rbank);
        end
        for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
            vectors++;
            if (acc_q[i] !== exp_word(1, i)) begin
                miscompares++;
                $display("FAIL bp_word%0d got=%h exp=%h", i, acc_q[i], exp_word(1, i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int s; int s2; bit ok;
        m_ready = 1'b1;
        clear_log();
        pulse_start(s);
        repeat (2) @(posedge clk);
        pulse_start(s2);
        wait_ends(2, 80, ok);
        vectors++;
        if (!ok || acc_q.size() != 16 || overrun !== 1'b0 || rbank !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_frames ended=%0d words=%0d overrun=%b bank=%b exp 1/16/0/0", ok, acc_q.size(), overrun, rbank);
        end
        for (int i = 0; i < 16 && i < acc_q.size(); i++) begin
            vectors++;
            if (acc_q[i] !== exp_word(i / 8, i % 8)) begin
                miscompares++;
                $display("FAIL b2b_word%0d got=%h exp=%h", i, acc_q[i], exp_word(i / 8, i % 8));
            end
        end
        vectors++;
        if (acc_q.size() < 9 || ep_cyc.size() < 1 || acc_cyc[8] != ep_cyc[0] + 3) begin
            miscompares++;
            $display("FAIL b2b_restart first word of frame 2 at wrong cycle (words=%0d) exp end+3", acc_q.size());
        end
    endtask

    task automatic test_coincident();
        int s; bit ok;
        m_ready = 1'b1;
        clear_log();
        pulse_start(s);
        // Frame ends with the m_last acceptance edge at s+10; start is sampled on that edge.
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_ends(2, 80, ok);
        vectors++;
        if (!ok || acc_q.size() != 16 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL coinc_frames ended=%0d words=%0d overrun=%b exp 1/16/0", ok, acc_q.size(), overrun);
        end
        for (int i = 8; i < 16 && i < acc_q.size(); i++) begin
            vectors++;
            if (acc_q[i] !== exp_word(1, i % 8)) begin
                miscompares++;
                $display("FAIL coinc_word%0d got=%h exp=%h", i, acc_q[i], exp_word(1, i % 8));
            end
        end
    endtask

    task automatic test_overrun();
        int s; bit ok;
        m_ready = 1'b1;
        clear_log();
        pulse_start(s);
        pulse_start(s);
        pulse_start(s);
        wait_ends(2, 80, ok);
        repeat (20) @(negedge clk);
        vectors++;
        if (!ok || ep_count != 2 || acc_q.size() != 16 || overrun !== 1'b1 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_frames ended=%0d ends=%0d words=%0d overrun=%b ready=%b exp 1/2/16/1/1", ok, ep_count, acc_q.size(), overrun, ready);
        end
        for (int i = 0; i < 16 && i < acc_q.size(); i++) begin
            vectors++;
            if (acc_q[i] !== exp_word(i / 8, i % 8)) begin
                miscompares++;
                $display("FAIL ovr_word%0d got=%h exp=%h", i, acc_q[i], exp_word(i / 8, i % 8));
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clear got=%b exp=0", overrun);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
        mem_dat = '0;
        prev_stall = 1'b0; prev_word = '0;
        clear_log();
        test_reset();
        test_basic();
        test_reset_midframe();
        test_backpressure();
        test_back_to_back();
        test_coincident();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifm_drain_reader.md
IFM_DRAIN_READER -- requirements
Module: ifm_drain_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of IFM memory and output stream.
REQ-002 SHALL have parameter IFM_SIZE, default 9, feature-map side length.
REQ-003 SHALL have parameter NUMBER_OF_IFM, default 28, maps per frame.
REQ-004 SHALL have derived parameter ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE), and MAP_SEL_BITS = $clog2(NUMBER_OF_IFM).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset (0 = asserted).
REQ-007 SHALL have port start_from_previous, input, 1, one-cycle pulse: producing layer finished writing a frame.
REQ-008 SHALL have port end_to_previous, output, 1, one-cycle pulse: frame fully drained, bank released.
REQ-009 SHALL have port ready, output, 1, high only in IDLE with no pending start.
REQ-010 SHALL have port ifm_enable_read, output, 1, IFM memory read strobe.
REQ-011 SHALL have port ifm_address_read, output, ADDRESS_SIZE_IFM, word address within map.
REQ-012 SHALL have port ifm_sel_map, output, MAP_SEL_BITS, selects map memory.
REQ-013 SHALL have port ifm_sel_bank, output, 1, ping-pong bank being read.
REQ-014 SHALL have port data_in_from_ifm, input, DATA_WIDTH, read data, valid one cycle after ifm_enable_read.
REQ-015 SHALL have ports m_valid/m_last (output,1), m_data (output,DATA_WIDTH), m_ready (input,1): output stream.
REQ-016 SHALL have port overrun, output, 1, sticky: start received while one already pending.

Function
REQ-017 SHALL implement FSM states IDLE, DRAIN, FLUSH.
REQ-018 IDLE -> DRAIN on start_from_previous (or pending start); map and address counters cleared to 0.
REQ-019 In DRAIN SHALL read words in order: address 0..IFM_SIZE^2-1 of map 0, then map 1, ... map NUMBER_OF_IFM-1; address wraps to 0 and map increments at map end.
REQ-020 Read latency fixed at 1 cycle; returned word SHALL enter a 2-entry output FIFO driving m_data/m_valid.
REQ-021 SHALL assert ifm_enable_read only when FIFO occupancy + in-flight reads < 2; no word ever dropped or duplicated under any m_ready pattern.
REQ-022 Throughput SHALL be 1 word/cycle with m_ready held high; first m_valid 2 cycles after start pulse.
REQ-023 m_data/m_valid/m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 m_last SHALL be 1 only on last word of map NUMBER_OF_IFM-1.
REQ-025 DRAIN -> FLUSH after last read issued; FLUSH -> IDLE when the m_last word is accepted (m_valid & m_ready).
REQ-026 end_to_previous SHALL pulse exactly one cycle, the cycle after m_last acceptance; ifm_sel_bank toggles same cycle.
REQ-027 ifm_sel_bank SHALL be constant during a frame.
REQ-028 start_from_previous outside IDLE SHALL set a one-deep pending flag; next frame begins the cycle after return to IDLE.
REQ-029 start while pending already set SHALL be dropped and set overrun until reset.
REQ-030 Start in same cycle as return to IDLE SHALL be captured (as pending or direct start), never lost.
REQ-031 ifm_address_read/ifm_sel_map SHALL hold last value when ifm_enable_read=0.

Reset
REQ-032 While reset=0: state IDLE, counters 0, FIFO empty, pending 0, overrun 0, ifm_sel_bank 0, all outputs 0 except ready=1.
REQ-033 Reset asserted mid-frame SHALL abort immediately; no end_to_previous issued; first post-reset frame reads bank 0.

Verification (IFM_SIZE=2, NUMBER_OF_IFM=2, 8 words/frame)
REQ-034 Start pulse, m_ready=1, memory returns {map,addr} -> m_data 0,1,2,3,0x10..0x13 on 8 consecutive cycles, m_last on word 8, end_to_previous 1 cycle later, ifm_sel_bank 0->1.
REQ-035 m_ready toggling 1,0,0,1 repeatedly -> same 8 words in order, no loss/duplication, m_data stable while stalled.
REQ-036 Second start during frame 1 -> frame 2 starts after end_to_previous, reads bank 1, overrun stays 0.
REQ-037 Three starts in one frame -> overrun=1, exactly two frames drained.
REQ-038 Reset low at word 5 -> outputs at reset values, no end_to_previous; new start reads bank 0 from address 0.
REQ-039 Start coincident with FLUSH->IDLE cycle -> next frame still drained fully.
